// File: rtl/fp_issue.sv
// fp_issue: in-order issue queue in front of the fpu.
// Ops wait until their result-port slot is free.
module fp_issue #(
  parameter int DEPTH      = 4,
  parameter int LNDEPTH    = 2,
  parameter int RV         = 64,
  parameter int CNTRL_SIZE = 7,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int LAT_ADD    = 3,
  parameter int LAT_MUL    = 4,
  localparam int HW = (LNHART > 0) ? LNHART : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNTRL_SIZE-1:0] in_control,
  input  logic [LNCOMMIT-1:0]   in_rd,
  input  logic [4:0]            in_immed,
  input  logic                  in_makes_rd,
  input  logic [HW-1:0]         in_hart,
  input  logic [RV-1:0]         in_fr1,
  input  logic [RV-1:0]         in_fr2,
  input  logic [RV-1:0]         in_fr3,
  input  logic [RV-1:0]         in_ir1,
  input  logic [NCOMMIT-1:0]    commit_kill_0,
  output logic                  enable,
  output logic [CNTRL_SIZE-1:0] control,
  output logic [LNCOMMIT-1:0]   rd,
  output logic [4:0]            immed,
  output logic                  makes_rd,
  output logic [HW-1:0]         hart,
  output logic [RV-1:0]         fr1,
  output logic [RV-1:0]         fr2,
  output logic [RV-1:0]         fr3,
  output logic [RV-1:0]         ir1,
  output logic                  busy
);

  typedef struct packed {
    logic [CNTRL_SIZE-1:0] control;
    logic [LNCOMMIT-1:0]   rd;
    logic [4:0]            immed;
    logic                  makes_rd;
    logic [HW-1:0]         hart;
    logic [RV-1:0]         fr1;
    logic [RV-1:0]         fr2;
    logic [RV-1:0]         fr3;
    logic [RV-1:0]         ir1;
  } entry_t;

  entry_t q [DEPTH];

  logic [DEPTH-1:0]   vld;
  logic [DEPTH-1:0]   dead;
  logic [DEPTH-1:0]   kill_hit;
  logic [LNDEPTH-1:0] head;
  logic [LNDEPTH-1:0] tail;
  logic [LNDEPTH-1:0] iss_idx;
  logic [LNDEPTH:0]   count;
  logic [LAT_MUL:1]   resv;
  logic [LAT_MUL:1]   lat_oh;
  logic [LAT_MUL:1]   resv_nxt;
  logic               iss_pend;

  entry_t h;
  logic   mul_cls;
  logic   add_cls;
  logic   hit;
  logic   live;
  logic   drop;
  logic   issue;
  logic   pop;
  logic   push;

  assign h = q[head];

  assign in_ready = count < (LNDEPTH+1)'(DEPTH);
  assign push     = in_valid & in_ready;
  assign busy     = (count != '0) | (|resv);

  assign mul_cls = h.control[4]
                 | (h.control[3:0] == 4'd2);
  assign add_cls = ~h.control[4]
                 & (h.control[3:0] <= 4'd1);

  // One-hot latency of the head op, indexed like resv.
  always_comb begin
    lat_oh = '0;
    unique case (1'b1)
      mul_cls: lat_oh[LAT_MUL] = 1'b1;
      add_cls: lat_oh[LAT_ADD] = 1'b1;
      default: lat_oh[2]       = 1'b1;
    endcase
  end

  assign hit   = |(resv & lat_oh);
  assign live  = vld[head] & ~dead[head]
               & ~commit_kill_0[h.rd];
  assign drop  = vld[head] & ~live;
  assign issue = live & ~hit;
  assign pop   = issue | drop;

  // Slot L-1 after the shift is slot L before it.
  assign resv_nxt = (resv >> 1)
                  | (issue ? (lat_oh >> 1) : '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_kill
    assign kill_hit[g] = vld[g]
                       & commit_kill_0[q[g].rd];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      dead  <= '0;
      resv  <= '0;
    end else begin
      resv <= resv_nxt;
      dead <= dead | kill_hit;
      if (push) begin
        vld[tail]  <= 1'b1;
        dead[tail] <= commit_kill_0[in_rd];
        tail       <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q[tail] <= '{
        control:  in_control,
        rd:       in_rd,
        immed:    in_immed,
        makes_rd: in_makes_rd,
        hart:     in_hart,
        fr1:      in_fr1,
        fr2:      in_fr2,
        fr3:      in_fr3,
        ir1:      in_ir1
      };
    end
  end

  // A popped slot is not refilled on the issue edge
  // (queue was not full), so iss_idx stays readable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      control  <= '0;
      rd       <= '0;
      immed    <= '0;
      makes_rd <= 1'b0;
      hart     <= '0;
      fr1      <= '0;
      fr2      <= '0;
      fr3      <= '0;
      ir1      <= '0;
      iss_pend <= 1'b0;
      iss_idx  <= '0;
    end else begin
      enable   <= issue;
      iss_pend <= issue;
      if (issue) begin
        control  <= h.control;
        rd       <= h.rd;
        immed    <= h.immed;
        makes_rd <= h.makes_rd;
        hart     <= h.hart;
        iss_idx  <= head;
      end
      if (iss_pend) begin
        fr1 <= q[iss_idx].fr1;
        fr2 <= q[iss_idx].fr2;
        fr3 <= q[iss_idx].fr3;
        ir1 <= q[iss_idx].ir1;
      end
    end
  end

endmodule

// File: tb/tb_fp_issue.sv
// tb_fp_issue: scoreboard bench for fp_issue.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_fp_issue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_control;
  logic [4:0]  in_rd;
  logic [4:0]  in_immed;
  logic        in_makes_rd;
  logic [0:0]  in_hart;
  logic [63:0] in_fr1, in_fr2, in_fr3, in_ir1;
  logic [31:0] commit_kill_0;
  logic        enable;
  logic [6:0]  control;
  logic [4:0]  rd;
  logic [4:0]  immed;
  logic        makes_rd;
  logic [0:0]  hart;
  logic [63:0] fr1, fr2, fr3, ir1;
  logic        busy;

  fp_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_rd(in_rd),
    .in_immed(in_immed), .in_makes_rd(in_makes_rd),
    .in_hart(in_hart),
    .in_fr1(in_fr1), .in_fr2(in_fr2),
    .in_fr3(in_fr3), .in_ir1(in_ir1),
    .commit_kill_0(commit_kill_0),
    .enable(enable), .control(control), .rd(rd),
    .immed(immed), .makes_rd(makes_rd), .hart(hart),
    .fr1(fr1), .fr2(fr2), .fr3(fr3), .ir1(ir1),
    .busy(busy)
  );

  typedef struct {
    logic [6:0]  control;
    logic [4:0]  rd;
    logic [4:0]  immed;
    logic        makes_rd;
    logic [0:0]  hart;
    logic [63:0] fr1, fr2, fr3, ir1;
    int          ecyc;
  } exp_t;

  exp_t sb[$];
  exp_t pe;
  bit   pend = 0;
  bit   port_used[int];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   saw_full = 0;
  bit   saw_refull = 0;
  bit   armed = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, req);
    end
  endtask

  function automatic int lat_of(input logic [6:0] c);
    if (c[4] || c[3:0] == 4'd2) return 4;
    if (c[3:0] <= 4'd1) return 3;
    return 2;
  endfunction

  function automatic logic [63:0] opv(input int k,
                                      input logic [4:0] r);
    return {4'(k), 28'hA5C3E1F, 27'h0, r};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   l;
    if (!reset) begin
      if (pend) begin
        chk("fr1", fr1, pe.fr1);
        chk("fr2", fr2, pe.fr2);
        chk("fr3", fr3, pe.fr3);
        chk("ir1", ir1, pe.ir1);
        pend = 0;
      end
      if (enable) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL spurious_enable: got rd=%0d required none",
                   rd);
        end else begin
          e = sb.pop_front();
          chk("rd", 64'(rd), 64'(e.rd));
          chk("control", 64'(control), 64'(e.control));
          chk("immed", 64'(immed), 64'(e.immed));
          chk("makes_rd", 64'(makes_rd), 64'(e.makes_rd));
          chk("hart", 64'(hart), 64'(e.hart));
          if (e.ecyc >= 0)
            chk("enable_cycle", 64'(cyc), 64'(e.ecyc));
          l = lat_of(control);
          checks++;
          if (port_used.exists(cyc + l)) begin
            fails++;
            $display("FAIL result_port: got collision at %0d rd=%0d required free",
                     cyc + l, rd);
          end
          port_used[cyc + l] = 1;
          pe   = e;
          pend = 1;
        end
      end
    end
  end

  task automatic push(input logic [6:0]  c,
                      input logic [4:0]  r,
                      input logic [31:0] kill,
                      input bit          expect_issue,
                      input int          off);
    int   tries;
    bit   ok;
    int   acc;
    exp_t e;
    tries         = 0;
    ok            = 0;
    in_valid      = 1;
    in_control    = c;
    in_rd         = r;
    in_immed      = r ^ 5'h15;
    in_makes_rd   = ~r[1];
    in_hart       = r[0];
    in_fr1        = opv(1, r);
    in_fr2        = opv(2, r);
    in_fr3        = opv(3, r);
    in_ir1        = opv(4, r);
    commit_kill_0 = kill;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) begin
        saw_full = 1;
        if (armed) saw_refull = 1;
      end
      @(posedge clk);
      #1;
      if (!ok) tries++;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL push_timeout: got in_ready=0 for rd=%0d required 1",
               r);
    end else begin
      acc = cyc;
      if (tries > 0) armed = 1;
      if (expect_issue) begin
        e.control  = c;
        e.rd       = r;
        e.immed    = r ^ 5'h15;
        e.makes_rd = ~r[1];
        e.hart     = r[0];
        e.fr1      = opv(1, r);
        e.fr2      = opv(2, r);
        e.fr3      = opv(3, r);
        e.ir1      = opv(4, r);
        e.ecyc     = (off > 0) ? acc + off : -1;
        sb.push_back(e);
      end
    end
    in_valid      = 0;
    commit_kill_0 = '0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    in_valid      = 0;
    commit_kill_0 = '0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1;
    in_valid      = 0;
    in_control    = '0;
    in_rd         = '0;
    in_immed      = '0;
    in_makes_rd   = 0;
    in_hart       = '0;
    in_fr1        = '0;
    in_fr2        = '0;
    in_fr3        = '0;
    in_ir1        = '0;
    commit_kill_0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fr1", fr1, 64'd0);
    chk("rst_control", 64'(control), 64'd0);
    reset = 0;
    @(posedge clk);
    #1;

    // back-to-back single-cycle ops
    push(7'h05, 5'd3, '0, 1, 1);
    push(7'h06, 5'd4, '0, 1, 1);
    drain("b2b");

    // fadd holds slot 2 for one cycle
    push(7'h00, 5'd1, '0, 1, 1);
    push(7'h05, 5'd2, '0, 1, 2);
    drain("add_fsgnj");

    // fmadd then fadd
    push(7'h10, 5'd7, '0, 1, 1);
    push(7'h00, 5'd8, '0, 1, 2);
    drain("mul_add");

    // killed on push, next op goes right behind
    push(7'h05, 5'd5, 32'h0000_0020, 0, 0);
    push(7'h05, 5'd6, '0, 1, 1);
    drain("kill");

    // alternating add/fsgnj builds up a backlog
    for (int i = 0; i < 16; i++)
      push((i % 2) ? 7'h05 : 7'h00, 5'(10 + i), '0, 1, 0);
    chk("saw_full", 64'(saw_full), 64'd1);
    chk("saw_refull", 64'(saw_refull), 64'd1);
    drain("fill");

    // reset with work queued and slots reserved
    for (int i = 0; i < 6; i++)
      push((i % 2) ? 7'h05 : 7'h00, 5'(20 + i), '0, 1, 0);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1;
    sb.delete();
    pend = 0;
    port_used.delete();
    #1;
    chk("mid_rst_enable", 64'(enable), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_control", 64'(control), 64'd0);
    chk("mid_rst_rd", 64'(rd), 64'd0);
    chk("mid_rst_fr1", fr1, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_enable", 64'(enable), 64'd0);
    reset = 0;
    push(7'h20, 5'd30, '0, 1, 1);
    push(7'h10, 5'd31, '0, 1, 1);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/fp_issue.md
Name: fp_issue

Overview:
- In-order issue queue that sits in front of the fpu execution unit and drives its issue interface: enable, control, rd, immed, makes_rd, hart, followed one cycle later by the operands fr1/fr2/fr3/ir1.
- The fpu has a single shared result port. 1-cycle ops, fp_add_sub and fp_mul have different latencies, so this block keeps a result-slot reservation vector and never issues an op whose result would collide with one already in flight.
- Entries named by commit_kill_0 are discarded before issue.

Parameters:
- DEPTH, 4, queue entries (power of 2)
- LNDEPTH, 2, log2(DEPTH)
- RV, 64, operand width
- CNTRL_SIZE, 7, fpu control width
- NHART, 1, number of harts
- LNHART, 0, log2(NHART)
- NCOMMIT, 32, commit registers
- LNCOMMIT, 5, log2(NCOMMIT)
- LAT_ADD, 3, cycles from enable to add result on the fpu result port
- LAT_MUL, 4, cycles from enable to mul/muladd result on the fpu result port (LAT_MUL >= LAT_ADD >= 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  new op offered
- in_ready  out  1  queue can accept (count < DEPTH)
- in_control  in  CNTRL_SIZE  fpu control ([5] size, [4] multiple, [3:0] op)
- in_rd  in  LNCOMMIT  destination commit register
- in_immed  in  5  immed[16:12] (rounding, xtra, xtra2)
- in_makes_rd  in  1  op writes a result
- in_hart  in  max(LNHART,1)  hart
- in_fr1, in_fr2, in_fr3  in  RV  FP operand values
- in_ir1  in  RV  integer operand value
- commit_kill_0  in  NCOMMIT  kill mask by commit register
- enable  out  1  fpu issue strobe
- control  out  CNTRL_SIZE  to fpu
- rd  out  LNCOMMIT  to fpu
- immed  out  5  to fpu
- makes_rd  out  1  to fpu
- hart  out  max(LNHART,1)  to fpu
- fr1, fr2, fr3, ir1  out  RV  operands, valid in the cycle after enable
- busy  out  1  queue non-empty or reservation vector non-zero

Behaviour:
- Reset (asynchronous): head=tail=0, count=0, all entry valid bits 0, enable=0, reservation vector=0, all field and operand output registers 0.
- Push: when in_valid && in_ready, write the entry at tail, tail++ (wraps mod DEPTH), valid=1.
  - in_ready depends on count only. When full, no push is accepted even if a pop happens in the same cycle.
- Latency class of head entry:
  - control[4]=1, or op==2: L=LAT_MUL.
  - control[4]=0 and op<=1: L=LAT_ADD.
  - Otherwise: L=2 (ops 3/4 are also issued as 1-cycle).
- Reservation vector: resv[LAT_MUL:1]; resv[k]=1 means the result port is busy k cycles from now.
  - Every cycle it shifts right by one: resv[k] <= resv[k+1], top bit <= 0.
  - Issue of a class-L op sets resv[L-1] in the post-shift vector.
- Issue: head is valid and not killed, and resv[L]==0 (pre-shift) -> enable=1 for exactly one cycle with all registered fields; head++, count--.
  - The next cycle, fr1/fr2/fr3/ir1 present that entry's operand values.
  - At most one issue per cycle.
  - If the head's slot is taken, the head stalls. There is no out-of-order bypass.
- Operand outputs hold their last value when there is no issue.
- Kill: every cycle, each valid entry whose commit_kill_0[rd]=1 is marked dead.
  - A dead head is popped with no enable and no reservation, one per cycle.
  - A kill applied to the entry being pushed in the same cycle also marks it dead.
  - An op already issued is not cancelled; its reservation stays.
- Simultaneous push+pop: count is unchanged and pointers advance independently. Empty plus push: the op cannot issue before the following cycle.
- busy=0 only when count==0 and resv==0.
- Reset mid-operation clears everything immediately. No enable is produced in the reset cycle or while reset is held.

Test Plan:
- Push fsgnj (op=5, rd=3), then fmin (op=6, rd=4) back-to-back -> enable in consecutive cycles with rd=3 then rd=4. Operands follow one cycle after each enable.
- Push fadd (op=0, rd=1), then fsgnj (op=5, rd=2) immediately, with LAT_ADD=3 -> fadd issues at N and fsgnj issues at N+2, not N+1, because slot 2 is held. No result-port overlap.
- Push fmadd (control[4]=1, rd=7) then fadd (rd=8), with LAT_MUL=4 and LAT_ADD=3 -> fadd is delayed until its slot is clear, and the two results reach the fpu result port in distinct cycles.
- Fill 4 entries behind a stalled head -> in_ready=0. in_valid held high is not accepted until the head issues, then count goes 4->3->4.
- Queue rd=5, rd=6 and assert commit_kill_0[5] before issue -> rd=5 is dropped without enable, and rd=6 issues one cycle later.
- Assert reset while 3 entries are queued and resv is non-zero -> outputs are 0 in the same cycle, busy=0, and the first push after reset issues normally.
